// File: rtl/sample_ring_buffer.sv
// Circular sample store: fills while a capture runs, freezes on done,
// then replays oldest-first as an AXI-stream burst terminated by tlast.
module sample_ring_buffer #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          abort,
  input  logic          capture_done,
  input  logic          rd_start,
  input  logic [AW:0]   buffer_size,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic [AW:0]   fill_count,
  output logic          wrapped,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    READ
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t state;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [AW:0]   len;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   issue_left;

  logic          rq_v;
  logic          rq_last;
  logic [DW-1:0] rq_data;

  logic [1:0]    cnt;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic          l0;
  logic          l1;

  logic [AW:0]   size_eff;
  logic [AW-1:0] start_ptr;
  logic [AW-1:0] rd_addr;
  logic [2:0]    occ;
  logic          wr_en;
  logic          wr_wrap;
  logic          pop;
  logic          credit;
  logic          start_rd;
  logic          rd_en;
  logic          is_last;

  function automatic logic [AW-1:0] step(
    input logic [AW-1:0] p,
    input logic [AW:0]   n
  );
    return ({1'b0, p} == n - ONE) ? '0 : p + AW'(1);
  endfunction

  assign size_eff  = (buffer_size == '0 || buffer_size > DEPTH)
                   ? DEPTH : buffer_size;
  assign wr_en     = state == FILL && s_tready && s_tvalid && !abort;
  assign wr_wrap   = {1'b0, wr_ptr} == len - ONE;
  assign start_ptr = wrapped ? wr_ptr : '0;

  assign pop    = cnt != 2'd0 && m_tready;
  assign occ    = 3'(cnt) + 3'(rq_v);
  // A slot is free if occupancy after this cycle's pop stays below two.
  assign credit = occ < 3'd2 || (pop && occ == 3'd2);

  // The first RAM read issues in the rd_start cycle to hit 2-cycle latency.
  assign start_rd = state == HOLD && rd_start && !abort
                 && fill_count != '0;
  assign rd_en    = start_rd
                 || (state == READ && !abort
                     && issue_left != '0 && credit);
  assign rd_addr  = state == HOLD ? start_ptr : rd_ptr;
  assign is_last  = state == HOLD ? fill_count == ONE
                                  : issue_left == ONE;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rq_data <= mem[rd_addr];
      rq_last <= is_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      s_tready   <= 1'b0;
      wrapped    <= 1'b0;
      fill_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len        <= DEPTH;
      issue_left <= '0;
      rq_v       <= 1'b0;
      cnt        <= 2'd0;
    end else if (abort) begin
      state      <= IDLE;
      s_tready   <= 1'b0;
      issue_left <= '0;
      rq_v       <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      rq_v <= rd_en;

      unique case ({rq_v, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= rq_data;
            l0 <= rq_last;
          end else begin
            d1 <= rq_data;
            l1 <= rq_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= rq_data;
            l0 <= rq_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= rq_data;
            l1 <= rq_last;
          end
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (arm) begin
            state      <= FILL;
            s_tready   <= 1'b1;
            wr_ptr     <= '0;
            fill_count <= '0;
            wrapped    <= 1'b0;
            len        <= size_eff;
          end
        end
        FILL: begin
          if (wr_en) begin
            wr_ptr <= step(wr_ptr, len);
            if (wr_wrap) begin
              wrapped <= 1'b1;
            end
            if (fill_count != len) begin
              fill_count <= fill_count + ONE;
            end
          end
          if (capture_done) begin
            state    <= HOLD;
            s_tready <= 1'b0;
          end
        end
        HOLD: begin
          if (rd_start) begin
            if (fill_count == '0) begin
              state <= IDLE;
            end else begin
              state      <= READ;
              rd_ptr     <= step(start_ptr, len);
              issue_left <= fill_count - ONE;
            end
          end
        end
        READ: begin
          if (rd_en) begin
            rd_ptr     <= step(rd_ptr, len);
            issue_left <= issue_left - ONE;
          end
          if (pop && l0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_tvalid = cnt != 2'd0;
  assign m_tdata  = d0;
  assign m_tlast  = m_tvalid && l0;
  assign busy     = state != IDLE;

endmodule

// File: tb/tb_sample_ring_buffer.sv
// Directed bench for sample_ring_buffer (AW=4): fill, wrap, stalled
// replay, latency, abort, empty replay and clamped ring length.
module tb_sample_ring_buffer;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic          abort;
  logic          capture_done;
  logic          rd_start;
  logic [AW:0]   buffer_size;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [AW:0]   fill_count;
  logic          wrapped;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sample_ring_buffer #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .capture_done (capture_done),
    .rd_start     (rd_start),
    .buffer_size  (buffer_size),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .fill_count   (fill_count),
    .wrapped      (wrapped),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm(input logic [AW:0] size);
    buffer_size = size;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_s_tready", 32'(s_tready), 32'd1);
  endtask

  task automatic push_seq(input int first, input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      s_tdata  = 32'(first + i);
      s_tvalid = 1'b1;
      capture_done = done_last && (i == n - 1);
      tick();
    end
    s_tvalid = 1'b0;
    capture_done = 1'b0;
  endtask

  task automatic do_done();
    capture_done = 1'b1;
    tick();
    capture_done = 1'b0;
    chk("hold_s_tready", 32'(s_tready), 32'd0);
  endtask

  task automatic burst(input string tag, input int first, input int n,
                       input logic [31:0] pat, input int plen);
    int k;
    int cyc;
    int first_v;
    bit held;
    logic [31:0] hold_d;
    k = 0;
    cyc = 0;
    first_v = -1;
    held = 1'b0;
    hold_d = '0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (k < n && cyc < 200) begin
      m_tready = (cyc < plen) ? pat[cyc] : 1'b1;
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (held) begin
        chk({tag, "_stall_v"}, 32'(m_tvalid), 32'd1);
        chk({tag, "_stall_d"}, m_tdata, hold_d);
      end
      if (m_tvalid && m_tready) begin
        chk({tag, "_data"}, m_tdata, 32'(first + k));
        chk({tag, "_last"}, 32'(m_tlast), 32'(k == n - 1));
        k++;
        held = 1'b0;
      end else if (m_tvalid) begin
        held = 1'b1;
        hold_d = m_tdata;
      end
      tick();
      cyc++;
    end
    m_tready = 1'b1;
    chk({tag, "_beats"}, 32'(k), 32'(n));
    chk({tag, "_lat"}, 32'(first_v), 32'd1);
    if (plen == 0) chk({tag, "_cycles"}, 32'(cyc), 32'(n + 1));
    chk({tag, "_end_v"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    capture_done = 1'b0;
    rd_start = 1'b0;
    buffer_size = '0;
    s_tdata = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);

    // T1
    do_arm(5'd8);
    chk("t1_busy", 32'(busy), 32'd1);
    push_seq(1, 5, 1'b0);
    do_done();
    chk("t1_fill", 32'(fill_count), 32'd5);
    chk("t1_wrapped", 32'(wrapped), 32'd0);
    burst("t1", 1, 5, 32'h0, 0);
    chk("t1_fill_kept", 32'(fill_count), 32'd5);

    // T2
    do_arm(5'd8);
    push_seq(1, 13, 1'b0);
    do_done();
    chk("t2_fill", 32'(fill_count), 32'd8);
    chk("t2_wrapped", 32'(wrapped), 32'd1);
    burst("t2", 6, 8, 32'h0, 0);

    // T3: ready 1,0,1,0 then low for five cycles
    do_arm(5'd8);
    push_seq(1, 13, 1'b0);
    do_done();
    burst("t3", 6, 8, 32'h5, 9);

    // T4
    do_arm(5'd16);
    push_seq(1, 16, 1'b0);
    do_done();
    chk("t4_fill", 32'(fill_count), 32'd16);
    chk("t4_wrapped", 32'(wrapped), 32'd1);
    burst("t4", 1, 16, 32'h0, 0);

    // T5: abort mid-replay
    do_arm(5'd8);
    push_seq(1, 6, 1'b0);
    do_done();
    s_tdata = 32'hdead;
    s_tvalid = 1'b1;
    arm = 1'b1;
    tick();
    s_tvalid = 1'b0;
    arm = 1'b0;
    chk("t5_hold_nowrite", 32'(fill_count), 32'd6);
    chk("t5_hold_noarm", 32'(s_tready), 32'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t5_beat_v", 32'(m_tvalid), 32'd1);
      chk("t5_beat_d", m_tdata, 32'(i + 1));
      tick();
    end
    m_tready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_tready = 1'b1;
    chk("t5_abort_v", 32'(m_tvalid), 32'd0);
    chk("t5_abort_last", 32'(m_tlast), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("t5_abort_v2", 32'(m_tvalid), 32'd0);
    do_arm(5'd8);
    push_seq(32'h21, 3, 1'b0);
    do_done();
    burst("t5_refill", 32'h21, 3, 32'h0, 0);
    do_arm(5'd8);
    do_done();
    chk("t5_empty_fill", 32'(fill_count), 32'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("t5_empty_busy", 32'(busy), 32'd0);
    repeat (3) begin
      chk("t5_empty_v", 32'(m_tvalid), 32'd0);
      tick();
    end

    // T6: size 0 clamps to 16, done coincident with the final sample
    do_arm(5'd0);
    push_seq(1, 20, 1'b1);
    chk("t6_s_tready", 32'(s_tready), 32'd0);
    chk("t6_fill", 32'(fill_count), 32'd16);
    chk("t6_wrapped", 32'(wrapped), 32'd1);
    burst("t6", 5, 16, 32'h0, 0);

    // reset mid-fill clears status
    do_arm(5'd8);
    push_seq(1, 3, 1'b0);
    chk("rst2_pre_fill", 32'(fill_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_fill", 32'(fill_count), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_s_tready", 32'(s_tready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
